// File: rtl/ps2_key_buffer.sv
// PS/2 scan-code buffer: picks out new make codes, drops break codes and optionally key repeats,
// and queues the accepted codes in a first-word-fall-through FIFO for the LCD writer.
module ps2_key_buffer #(
    parameter int DEPTH_LOG2      = 3,
    parameter bit SUPPRESS_REPEAT = 1'b1
) (
    input  logic                  Clock_50,
    input  logic                  Resetn,
    input  logic [7:0]            PS2_code,
    input  logic                  PS2_code_ready,
    input  logic                  PS2_make_code,
    input  logic                  Flush,
    input  logic                  Key_pop,
    output logic                  Key_valid,
    output logic [7:0]            Key_code,
    output logic [DEPTH_LOG2:0]   Key_fill,
    output logic [7:0]            Overflow_count
);

    localparam int DEPTH = 1 << DEPTH_LOG2;

    // state      | meaning
    // S_NO_KEY   | no key held; the next make code is always accepted
    // S_KEY_HELD | a key is held; last_code_q holds its make code
    typedef enum logic {S_NO_KEY, S_KEY_HELD} held_t;

    held_t                 held_q, held_d;
    logic [7:0]            last_code_q, last_code_d;
    logic                  ready_buf_q;
    logic [DEPTH_LOG2:0]   wr_cnt_q, wr_cnt_d;
    logic [DEPTH_LOG2:0]   rd_cnt_q, rd_cnt_d;
    logic [7:0]            key_code_q, key_code_d;
    logic [7:0]            ovf_q, ovf_d;
    logic [7:0]            mem_q [DEPTH];

    logic                  ps2_event;
    logic                  is_repeat;
    logic                  accept;
    logic [DEPTH_LOG2:0]   fill;
    logic [DEPTH_LOG2:0]   fill_d;
    logic                  full;
    logic                  empty;
    logic                  do_pop;
    logic                  do_push;
    logic                  drop;

    assign ps2_event = PS2_code_ready & ~ready_buf_q;
    assign is_repeat = SUPPRESS_REPEAT && (held_q == S_KEY_HELD) && (PS2_code == last_code_q);
    assign accept    = ps2_event & PS2_make_code & ~is_repeat;

    assign fill    = wr_cnt_q - rd_cnt_q;
    assign full    = (fill == (DEPTH_LOG2+1)'(DEPTH));
    assign empty   = (fill == '0);
    assign do_pop  = Key_pop & ~empty;
    // A full FIFO still accepts when the consumer frees a slot on the same edge.
    assign do_push = accept & (~full | do_pop);
    assign drop    = accept & full & ~do_pop;

    assign fill_d  = wr_cnt_d - rd_cnt_d;

    always_comb begin
        held_d      = held_q;
        last_code_d = last_code_q;
        wr_cnt_d    = wr_cnt_q;
        rd_cnt_d    = rd_cnt_q;
        ovf_d       = ovf_q;
        key_code_d  = key_code_q;

        if (Flush) begin
            held_d     = S_NO_KEY;
            rd_cnt_d   = wr_cnt_q;
            key_code_d = 8'h00;
        end else begin
            if (ps2_event) begin
                if (!PS2_make_code) begin
                    held_d = S_NO_KEY;
                end else if (!is_repeat) begin
                    held_d      = S_KEY_HELD;
                    last_code_d = PS2_code;
                end
            end

            if (do_push) wr_cnt_d = wr_cnt_q + 1'b1;
            if (do_pop)  rd_cnt_d = rd_cnt_q + 1'b1;
            if (drop && ovf_q != 8'hFF) ovf_d = ovf_q + 8'd1;

            // The new head may be the word being written this edge, so bypass it from the input.
            if (fill_d == '0)
                key_code_d = 8'h00;
            else if (do_push && (rd_cnt_d[DEPTH_LOG2-1:0] == wr_cnt_q[DEPTH_LOG2-1:0]))
                key_code_d = PS2_code;
            else
                key_code_d = mem_q[rd_cnt_d[DEPTH_LOG2-1:0]];
        end
    end

    always_ff @(posedge Clock_50 or negedge Resetn) begin
        if (!Resetn) begin
            held_q      <= S_NO_KEY;
            last_code_q <= 8'h00;
            ready_buf_q <= 1'b0;
            wr_cnt_q    <= '0;
            rd_cnt_q    <= '0;
            key_code_q  <= 8'h00;
            ovf_q       <= 8'h00;
        end else begin
            held_q      <= held_d;
            last_code_q <= last_code_d;
            ready_buf_q <= PS2_code_ready;
            wr_cnt_q    <= wr_cnt_d;
            rd_cnt_q    <= rd_cnt_d;
            key_code_q  <= key_code_d;
            ovf_q       <= ovf_d;
        end
    end

    always_ff @(posedge Clock_50) begin
        if (do_push && !Flush)
            mem_q[wr_cnt_q[DEPTH_LOG2-1:0]] <= PS2_code;
    end

    assign Key_valid      = ~empty;
    assign Key_fill       = fill;
    assign Key_code       = key_code_q;
    assign Overflow_count = ovf_q;

endmodule
